// File: rtl/sha_feed_pkg.sv
// Shared definitions for the SHA-256 message feeder.
// Contents: block-type encodings, FSM state type, padding constants,
//           header depth and a byte-swap helper for the nonce.
package sha_feed_pkg;

    typedef enum logic [1:0] {
        MODE_HDR0 = 2'd0,   // first 64 bytes of the 80-byte header
        MODE_HDR1 = 2'd1,   // header tail + nonce + padding
        MODE_DIG  = 2'd2,   // second pass over a 256-bit digest
        MODE_RSVD = 2'd3
    } feed_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } feed_state_e;

    localparam logic [31:0] PAD_WORD  = 32'h8000_0000;
    localparam logic [31:0] LEN_HDR   = 32'h0000_0280;  // 640-bit header
    localparam logic [31:0] LEN_DIG   = 32'h0000_0100;  // 256-bit digest
    localparam int          HDR_WORDS = 20;

    // The nonce arrives as a native integer but is hashed little-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha_msg_feeder_if.sv
// Word-fetch handshake between a SHA-256 core and the message feeder.
// Ports: rq/addr driven by the core (master); rdy/data returned by the
//        feeder (slave) one cycle after an accepted request.
interface sha_msg_feeder_if;
    logic        rq;
    logic [3:0]  addr;
    logic        rdy;
    logic [31:0] data;

    modport master (output rq, addr, input rdy, data);
    modport slave  (input rq, addr, output rdy, data);
endinterface

// File: rtl/sha_pad_word.sv
// Combinational word selector for the padded blocks (HDR1 and DIG).
// Inputs : mode, word index addr, header words 16..18, byte-swapped nonce,
//          256-bit digest (word 0 in [255:224]).
// Output : word, the 32-bit message word for that index (0 for HDR0/RSVD,
//          which the top serves straight from the header array).
module sha_pad_word
    import sha_feed_pkg::*;
(
    input  feed_mode_e  mode,
    input  logic [3:0]  addr,
    input  logic [31:0] hdr16,
    input  logic [31:0] hdr17,
    input  logic [31:0] hdr18,
    input  logic [31:0] nonce,
    input  logic [255:0] digest,
    output logic [31:0] word
);

    logic [7:0][31:0] dig_w;

    // dig_w[7] is digest word 0.
    assign dig_w = digest;

    always_comb begin
        word = '0;
        case (mode)
            MODE_HDR1: begin
                case (addr)
                    4'd0:    word = hdr16;
                    4'd1:    word = hdr17;
                    4'd2:    word = hdr18;
                    4'd3:    word = nonce;
                    4'd4:    word = PAD_WORD;
                    4'd15:   word = LEN_HDR;
                    default: word = '0;
                endcase
            end
            MODE_DIG: begin
                if (addr[3] == 1'b0) begin
                    word = dig_w[3'd7 - addr[2:0]];
                end else if (addr == 4'd8) begin
                    word = PAD_WORD;
                end else if (addr == 4'd15) begin
                    word = LEN_DIG;
                end
            end
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/sha_msg_feeder.sv
// Serves 16-word SHA-256 message blocks to a hash core on request.
// Ports: clk, rst (sync, active-high); load_we/load_addr/load_data write the
//        20-word header; arm/mode/nonce_in/digest_in start a block; core is
//        the rq/addr -> rdy/data fetch interface; busy, block_done, err status.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for arm; header writable; requests ignored
// ST_SERVE | answering word requests until 16 words have been returned
module sha_msg_feeder
    import sha_feed_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load_we,
    input  logic [4:0]      load_addr,
    input  logic [31:0]     load_data,
    input  logic            arm,
    input  logic [1:0]      mode,
    input  logic [31:0]     nonce_in,
    input  logic [255:0]    digest_in,
    sha_msg_feeder_if.slave core,
    output logic            busy,
    output logic            block_done,
    output logic            err
);

    feed_state_e  state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         rdy_q, rdy_d;
    logic [31:0]  data_q, data_d;
    logic         done_d, err_d;
    logic         start;

    feed_mode_e   mode_q;
    logic [31:0]  nonce_q;
    logic [255:0] digest_q;
    logic [31:0]  hdr [HDR_WORDS];

    logic [31:0]  pad_word;
    logic [31:0]  word_sel;

    assign start = (state_q == ST_IDLE) && arm && (mode != MODE_RSVD);
    assign busy  = (state_q == ST_SERVE);

    assign core.rdy  = rdy_q;
    assign core.data = data_q;

    // Header and latched block parameters are deliberately not reset so a
    // core reset does not force the host to reload the header.
    always_ff @(posedge clk) begin
        if (!rst && load_we && !busy && (load_addr < 5'(HDR_WORDS))) begin
            hdr[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && start) begin
            mode_q   <= feed_mode_e'(mode);
            nonce_q  <= bswap32(nonce_in);
            digest_q <= digest_in;
        end
    end

    sha_pad_word u_pad (
        .mode   (mode_q),
        .addr   (core.addr),
        .hdr16  (hdr[16]),
        .hdr17  (hdr[17]),
        .hdr18  (hdr[18]),
        .nonce  (nonce_q),
        .digest (digest_q),
        .word   (pad_word)
    );

    // The served word is decoded from the requested address, not the count.
    assign word_sel = (mode_q == MODE_HDR0) ? hdr[core.addr] : pad_word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_d   = 1'b0;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    if (mode == MODE_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_SERVE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_SERVE: begin
                // A request seen while rdy is high is the one just answered,
                // so it is not accepted again; this forces a gap between pulses.
                if (core.rq && !rdy_q) begin
                    rdy_d  = 1'b1;
                    data_d = word_sel;
                end
                if (rdy_q) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rdy_q      <= 1'b0;
            data_q     <= '0;
            block_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdy_q      <= rdy_d;
            data_q     <= data_d;
            block_done <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_sha_msg_feeder.sv
// Self-checking bench for sha_msg_feeder: directed and randomized blocks
// checked against a padded-message reference, plus a SHA-256 model used to
// hash the Bitcoin genesis header end-to-end through the feeder.
module tb_sha_msg_feeder;
    import sha_feed_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_we;
    logic [4:0]   load_addr;
    logic [31:0]  load_data;
    logic         arm;
    logic [1:0]   mode;
    logic [31:0]  nonce_in;
    logic [255:0] digest_in;
    logic         busy, block_done, err;

    sha_msg_feeder_if core ();

    sha_msg_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .arm        (arm),
        .mode       (mode),
        .nonce_in   (nonce_in),
        .digest_in  (digest_in),
        .core       (core),
        .busy       (busy),
        .block_done (block_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [31:0]  m_hdr [20];
    int           ref_mode;
    logic [31:0]  ref_nonce;
    logic [255:0] ref_dig;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] SHA_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One SHA-256 compression of a 512-bit block (word 0 in the top bits).
    function automatic logic [255:0] sha_blk(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] hh [8];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        logic [255:0] hout;
        for (int i = 0; i < 8; i++) hh[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3))
                 + w[t-7] + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
        a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3];
        e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        hout = {hh[0] + a, hh[1] + b, hh[2] + c, hh[3] + d,
                hh[4] + e, hh[5] + f, hh[6] + g, hh[7] + h};
        return hout;
    endfunction

    // Reference: build the SHA-padded message and pick the requested word
    // from the block that the mode refers to.
    function automatic logic [31:0] ref_word(input int m, input int k);
        logic [31:0] msg [$];
        logic [31:0] sw;
        int          nbits;
        if (m == 2) begin
            for (int i = 0; i < 8; i++) msg.push_back(ref_dig[255 - 32*i -: 32]);
        end else begin
            for (int i = 0; i < 19; i++) msg.push_back(m_hdr[i]);
            sw = {<<8{ref_nonce}};
            msg.push_back(sw);
        end
        nbits = msg.size() * 32;
        msg.push_back(32'h8000_0000);
        while (msg.size() % 16 != 15) msg.push_back(32'h0);
        msg.push_back(nbits);
        return msg[(m == 1 ? 16 : 0) + k];
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [31:0] dv, input bit upd);
        load_we = 1'b1; load_addr = a[4:0]; load_data = dv;
        tick();
        load_we = 1'b0;
        if (upd) m_hdr[a] = dv;
    endtask

    task automatic arm_blk(input int m, input logic [31:0] n, input logic [255:0] dg);
        arm = 1'b1; mode = m[1:0]; nonce_in = n; digest_in = dg;
        tick();
        arm = 1'b0;
        ref_mode = m; ref_nonce = n; ref_dig = dg;
        chk("busy_after_arm", {255'd0, busy}, 256'd1);
    endtask

    task automatic fetch(input int k, output logic [31:0] dv);
        int w = 0;
        core.rq = 1'b1; core.addr = k[3:0];
        do begin
            tick();
            w++;
        end while (!core.rdy && w < 8);
        core.rq = 1'b0;
        chk($sformatf("rdy_seen a%0d", k), {255'd0, core.rdy}, 256'd1);
        dv = core.data;
    endtask

    task automatic serve_block(input int first, input bit rnd, output logic [511:0] blk);
        logic [31:0] dv;
        int          a;
        blk = '0;
        for (int i = first; i < 16; i++) begin
            a = rnd ? int'($urandom_range(15, 0)) : i;
            fetch(a, dv);
            chk($sformatf("word m%0d a%0d", ref_mode, a), {224'd0, dv}, {224'd0, ref_word(ref_mode, a)});
            chk("no_early_done", {255'd0, block_done}, 256'd0);
            blk[511 - 32*a -: 32] = dv;
            if (rnd && i < 15) repeat ($urandom_range(2, 0)) tick();
        end
        tick();
        chk("block_done_pulse", {255'd0, block_done}, 256'd1);
        chk("busy_clear_at_done", {255'd0, busy}, 256'd0);
        tick();
        chk("block_done_one_cycle", {255'd0, block_done}, 256'd0);
    endtask

    initial begin
        logic [511:0] b0, b1, b2;
        logic [255:0] d1, d2, dg;
        logic [639:0] gen;
        logic [31:0]  dv;

        rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
        arm = 1'b0; mode = '0; nonce_in = '0; digest_in = '0;
        core.rq = 1'b0; core.addr = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_rdy",   {255'd0, core.rdy},   256'd0);
        chk("rst_data",  {224'd0, core.data},  256'd0);
        chk("rst_busy",  {255'd0, busy},       256'd0);
        chk("rst_done",  {255'd0, block_done}, 256'd0);
        chk("rst_err",   {255'd0, err},        256'd0);

        // HDR0 with a counting header
        for (int k = 0; k < 20; k++) load_word(k, 32'h1000 + k, 1'b1);
        arm_blk(0, 32'h0, '0);
        serve_block(0, 1'b0, b0);
        chk("hdr0_w0",  {224'd0, b0[511:480]}, {224'd0, 32'h1000});
        chk("hdr0_w15", {224'd0, b0[31:0]},    {224'd0, 32'h100F});

        // HDR1
        arm_blk(1, 32'h1234_5678, '0);
        serve_block(0, 1'b0, b1);
        chk("hdr1_w0",  {224'd0, b1[511:480]}, {224'd0, 32'h1010});
        chk("hdr1_w3",  {224'd0, b1[415:384]}, {224'd0, 32'h7856_3412});
        chk("hdr1_w4",  {224'd0, b1[383:352]}, {224'd0, 32'h8000_0000});
        chk("hdr1_w15", {224'd0, b1[31:0]},    {224'd0, 32'h0000_0280});

        // DIG with SHA-256("abc")
        arm_blk(2, 32'h0, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        serve_block(0, 1'b0, b2);
        chk("dig_words", {b2[511:256]}, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        chk("dig_w8",  {224'd0, b2[255:224]}, {224'd0, 32'h8000_0000});
        chk("dig_w15", {224'd0, b2[31:0]},    {224'd0, 32'h0000_0100});

        // Handshake: rq held high -> rdy only on alternate cycles
        arm_blk(0, 32'h0, '0);
        core.rq = 1'b1; core.addr = 4'd5;
        chk("hs_c1", {255'd0, core.rdy}, 256'd0);
        tick(); chk("hs_c2", {255'd0, core.rdy}, 256'd1);
        chk("hs_c2_data", {224'd0, core.data}, {224'd0, ref_word(0, 5)});
        tick(); chk("hs_c3", {255'd0, core.rdy}, 256'd0);
        tick(); chk("hs_c4", {255'd0, core.rdy}, 256'd1);
        tick(); chk("hs_c5", {255'd0, core.rdy}, 256'd0);
        core.rq = 1'b0;
        tick(); chk("hs_c6", {255'd0, core.rdy}, 256'd0);
        serve_block(2, 1'b0, b0);

        // rq while idle
        core.rq = 1'b1; core.addr = 4'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_rq_rdy", {255'd0, core.rdy}, 256'd0);
        end
        core.rq = 1'b0;

        // Reserved mode
        arm = 1'b1; mode = 2'd3;
        tick();
        arm = 1'b0;
        chk("err_pulse", {255'd0, err},  256'd1);
        chk("err_busy",  {255'd0, busy}, 256'd0);
        tick();
        chk("err_one_cycle", {255'd0, err}, 256'd0);

        // Arm and header write while busy are ignored
        arm_blk(1, 32'hA1B2_C3D4, '0);
        arm = 1'b1; mode = 2'd2; nonce_in = 32'h5555_AAAA; digest_in = '1;
        tick();
        arm = 1'b0;
        load_word(16, 32'hDEAD_BEEF, 1'b0);
        chk("busy_after_rearm", {255'd0, busy}, 256'd1);
        serve_block(0, 1'b0, b1);
        chk("hdr16_kept", {224'd0, b1[511:480]}, {224'd0, 32'h1010});

        // Reset after 7 words aborts the block
        arm_blk(0, 32'h0, '0);
        for (int k = 0; k < 7; k++) begin
            fetch(k, dv);
            chk($sformatf("pre_rst a%0d", k), {224'd0, dv}, {224'd0, ref_word(0, k)});
        end
        rst = 1'b1; arm = 1'b1; mode = 2'd1; core.rq = 1'b1;
        tick();
        rst = 1'b0; arm = 1'b0; core.rq = 1'b0;
        chk("abort_busy", {255'd0, busy},       256'd0);
        chk("abort_rdy",  {255'd0, core.rdy},   256'd0);
        chk("abort_done", {255'd0, block_done}, 256'd0);
        tick();
        chk("abort_done2", {255'd0, block_done}, 256'd0);
        arm_blk(0, 32'h0, '0);
        serve_block(0, 1'b0, b0);

        // Randomized blocks with random address order and request gaps
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 20; k++) load_word(k, $urandom, 1'b1);
            for (int i = 0; i < 8; i++) dg[255 - 32*i -: 32] = $urandom;
            arm_blk(int'($urandom_range(2, 0)), $urandom, dg);
            serve_block(0, 1'b1, b0);
        end

        // Bitcoin genesis header, double SHA-256 through the feeder
        gen = {32'h01000000, 256'h0,
               32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
               32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a,
               32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
        for (int k = 0; k < 20; k++) load_word(k, gen[639 - 32*k -: 32], 1'b1);
        arm_blk(0, 32'h0, '0);
        serve_block(0, 1'b0, b0);
        arm_blk(1, 32'h7c2bac1d, '0);
        serve_block(0, 1'b0, b1);
        d1 = sha_blk(sha_blk(SHA_IV, b0), b1);
        arm_blk(2, 32'h0, d1);
        serve_block(0, 1'b0, b2);
        d2 = sha_blk(SHA_IV, b2);
        chk("genesis_hash", d2, 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
